// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative restoring divider, 2N/N -> N quotient and remainder
// Early exit for divide-by-zero and quotient overflow; otherwise one quotient bit per cycle.
module seq_restoring_divider #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*N-1:0] Z,
   input  logic [N-1:0]   Y,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   Q,
   output logic [N-1:0]   R,
   output logic           ovf,
   output logic           dz
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_next;

   logic [N:0]    p;
   logic [N-1:0]  a;
   logic [N-1:0]  y_r;
   logic [CW-1:0] cnt;

   logic [N:0]    t_val;
   logic [N:0]    p_next;
   logic          q_bit;
   logic          accept;
   logic          quick;

   // Trial subtraction is N+1 bits wide so the bit shifted out of P is kept.
   always_comb begin
      t_val  = {p[N-1:0], a[N-1]};
      q_bit  = (t_val >= {1'b0, y_r});
      p_next = q_bit ? (t_val - {1'b0, y_r}) : t_val;
      accept = (state == IDLE) && start;
      quick  = (Y == '0) || (Z[2*N-1:N] >= Y);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (accept)
               state_next = quick ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST)
               state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p   <= '0;
         a   <= '0;
         y_r <= '0;
         cnt <= '0;
         Q   <= '0;
         R   <= '0;
         ovf <= 1'b0;
         dz  <= 1'b0;
      end else begin
         if (accept) begin
            y_r <= Y;
            ovf <= 1'b0;
            dz  <= 1'b0;
            if (Y == '0) begin
               dz  <= 1'b1;
               ovf <= 1'b1;
               Q   <= '1;
               R   <= Z[N-1:0];
            end else if (Z[2*N-1:N] >= Y) begin
               ovf <= 1'b1;
               Q   <= '1;
               R   <= Z[N-1:0];
            end else begin
               p   <= {1'b0, Z[2*N-1:N]};
               a   <= Z[N-1:0];
               cnt <= '0;
            end
         end else if (state == RUN) begin
            p   <= p_next;
            a   <= {a[N-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
               Q <= {a[N-2:0], q_bit};
               R <= p_next[N-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized self-checking bench for seq_restoring_divider
// Expected results come from plain 64-bit division in the bench.
module tb_seq_restoring_divider;

   localparam int N = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   Z = '0;
   logic [15:0]   Y = '0;
   logic          busy, done, ovf, dz;
   logic [15:0]   Q, R;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   seq_restoring_divider #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .Z(Z), .Y(Y),
      .busy(busy), .done(done), .Q(Q), .R(R), .ovf(ovf), .dz(dz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected result from the arithmetic definition of the divider.
   task automatic ref_div(input logic [31:0] z, input logic [15:0] y,
                          output logic [15:0] eq, output logic [15:0] er,
                          output logic eovf, output logic edz);
      longint unsigned q64;
      edz  = (y == 0);
      q64  = edz ? 64'd0 : longint'(z) / longint'(y);
      eovf = edz || (q64 > 64'hFFFF);
      if (eovf) begin
         eq = 16'hFFFF;
         er = z[15:0];
      end else begin
         eq = q64[15:0];
         er = 16'(longint'(z) % longint'(y));
      end
   endtask

   // Issues one start at the current negedge, scrambles inputs afterwards,
   // waits for done (bounded) and returns at the negedge after done.
   task automatic run_op(input logic [31:0] z, input logic [15:0] y,
                         output int lat, output int bcnt, output int start_cyc);
      Z = z; Y = y; start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      Z = $urandom; Y = 16'($urandom);
      lat = 0; bcnt = 0;
      for (int i = 1; i <= 40; i++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; Z = 32'd1000; Y = 16'd7;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, ovf, dz} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got busy/done/ovf/dz=%b expected 0000", {busy, done, ovf, dz});
      end
      n_checks++;
      if ({Q, R} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_qr: got Q=%h R=%h expected 0 0", Q, R);
      end
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bcnt, sc;
      run_op(32'd1000, 16'd7, lat, bcnt, sc);
      n_checks++;
      if (lat !== N + 1) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d expected %0d", lat, N + 1);
      end
      n_checks++;
      if (bcnt !== N + 1) begin
         n_fail++;
         $display("FAIL basic_busy_cycles: got %0d expected %0d", bcnt, N + 1);
      end
      n_checks++;
      if ({Q, R, ovf, dz} !== {16'd142, 16'd6, 2'b00}) begin
         n_fail++;
         $display("FAIL basic_result: got Q=%0d R=%0d ovf=%b dz=%b expected 142 6 0 0", Q, R, ovf, dz);
      end
   endtask

   task automatic test_max();
      int lat, bcnt, sc;
      longint unsigned recon;
      run_op(32'hFFFE0001, 16'hFFFF, lat, bcnt, sc);
      recon = longint'(Q) * longint'(16'hFFFF) + longint'(R);
      n_checks++;
      if ({Q, R, ovf, dz} !== {16'hFFFF, 16'h0000, 2'b00}) begin
         n_fail++;
         $display("FAIL max_result: got Q=%h R=%h ovf=%b dz=%b expected ffff 0000 0 0", Q, R, ovf, dz);
      end
      n_checks++;
      if (recon !== 64'hFFFE0001) begin
         n_fail++;
         $display("FAIL max_reconstruct: got %h expected fffe0001", recon);
      end
   endtask

   task automatic test_div_zero();
      int lat, bcnt, sc;
      run_op(32'h12345678, 16'h0000, lat, bcnt, sc);
      n_checks++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL dz_latency: got %0d expected 1", lat);
      end
      n_checks++;
      if ({Q, R, ovf, dz} !== {16'hFFFF, 16'h5678, 2'b11}) begin
         n_fail++;
         $display("FAIL dz_result: got Q=%h R=%h ovf=%b dz=%b expected ffff 5678 1 1", Q, R, ovf, dz);
      end
   endtask

   task automatic test_overflow();
      int lat, bcnt, sc;
      run_op(32'h00050000, 16'd5, lat, bcnt, sc);
      n_checks++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL ovf_latency: got %0d expected 1", lat);
      end
      n_checks++;
      if ({Q, R, ovf, dz} !== {16'hFFFF, 16'h0000, 2'b10}) begin
         n_fail++;
         $display("FAIL ovf_result: got Q=%h R=%h ovf=%b dz=%b expected ffff 0000 1 0", Q, R, ovf, dz);
      end
   endtask

   task automatic test_ignore_and_abort();
      int lat, n_done;
      // Second start while busy must be dropped.
      Z = 32'd1000; Y = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      Z = 32'd50; Y = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            lat = i + 1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (lat == 0 || {Q, R} !== {16'd142, 16'd6}) begin
         n_fail++;
         $display("FAIL ignore_start: got Q=%0d R=%0d seen_done=%0d expected 142 6", Q, R, lat);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_not_queued: got busy=%b expected 0", busy);
      end
      // Reset in the 5th RUN cycle abandons the operation.
      Z = 32'd50; Y = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({busy, done, Q, R} !== 34'h0) begin
         n_fail++;
         $display("FAIL abort_state: got busy=%b done=%b Q=%h R=%h expected 0 0 0 0", busy, done, Q, R);
      end
      n_done = 0;
      for (int i = 0; i < 25; i++) begin
         if (done) n_done++;
         @(negedge clk);
      end
      n_checks++;
      if (n_done !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d done pulses expected 0", n_done);
      end
      begin
         int l2, b2, s2;
         run_op(32'd50, 16'd3, l2, b2, s2);
      end
      n_checks++;
      if ({Q, R, ovf, dz} !== {16'd16, 16'd2, 2'b00}) begin
         n_fail++;
         $display("FAIL abort_fresh: got Q=%0d R=%0d ovf=%b dz=%b expected 16 2 0 0", Q, R, ovf, dz);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt, sc, prev_sc;
      logic [31:0] z;
      logic [15:0] y, zhi, eq, er;
      logic eovf, edz;
      prev_sc = -1;
      for (int k = 0; k < 500; k++) begin
         y   = 16'($urandom_range(1, 65535));
         zhi = 16'($urandom % y);
         z   = {zhi, 16'($urandom)};
         ref_div(z, y, eq, er, eovf, edz);
         run_op(z, y, lat, bcnt, sc);
         n_checks++;
         if ({Q, R, ovf, dz} !== {eq, er, eovf, edz}) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: Z=%h Y=%h got Q=%h R=%h ovf=%b dz=%b expected %h %h %b %b",
                     k, z, y, Q, R, ovf, dz, eq, er, eovf, edz);
         end
         n_checks++;
         if (!(R < y) || lat != N + 1) begin
            n_fail++;
            $display("FAIL b2b_bounds[%0d]: got R=%h latency=%0d expected R<%h latency=%0d", k, R, lat, y, N + 1);
         end
         if (prev_sc >= 0) begin
            n_checks++;
            if (sc - prev_sc != N + 2) begin
               n_fail++;
               $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, sc - prev_sc, N + 2);
            end
         end
         prev_sc = sc;
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_max();
      test_div_zero();
      test_overflow();
      test_ignore_and_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative restoring divider; the inverse of the team's karatsuba_16 multiplier.
- Takes a 2N-bit dividend Z and an N-bit divisor Y, and returns an N-bit quotient Q and an N-bit remainder R such that Z = Q*Y + R.
- Processes one quotient bit per clock behind a start/done handshake.
- Sits beside the Karatsuba datapath so results can be cross-checked against karatsuba_16.

Parameters:
N, 16, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits each.

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
Z  input  2N  dividend; captured on accepted start
Y  input  N  divisor; captured on accepted start
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse; Q/R/ovf/dz valid from this cycle
Q  output  N  quotient; held until next accepted start
R  output  N  remainder; held until next accepted start
ovf  output  1  quotient does not fit in N bits (includes Y==0)
dz  output  1  divide by zero

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - busy, done, Q, R, ovf and dz all go to 0.
  - Any operation in flight is abandoned; no done pulse is produced for it.
  - Reset has priority over start.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge t: capture Z and Y, clear ovf/dz, then take exactly one path below.
  - Y==0:
    - dz=1, ovf=1, Q={N{1}}, R=Z[N-1:0].
    - Go to DONE; done is high during cycle t+1.
  - Y!=0 and Z[2N-1:N] >= Y:
    - ovf=1, dz=0, Q={N{1}}, R=Z[N-1:0].
    - Go to DONE; done is high during cycle t+1.
  - Otherwise:
    - Load partial remainder P (N+1 bits) = {0, Z[2N-1:N]}.
    - Load shift register A = Z[N-1:0].
    - Load iteration counter = 0; go to RUN.
- RUN: one iteration per cycle, exactly N cycles.
  - T = {P[N-1:0], A[N-1]}.
  - If T >= {0,Y}: P = T - Y, quotient bit = 1; else P = T, quotient bit = 0.
  - A = {A[N-2:0], quotient bit}.
  - After the N-th iteration: Q = A, R = P[N-1:0], go to DONE.
- DONE: done=1, busy=1 for one cycle; then go to IDLE.
- Normal-path timing:
  - done is high during cycle t+N+1.
  - busy is high during cycles t+1 .. t+N+1.
- start while busy=1 is ignored; it is not queued.
- A new start is accepted in the first IDLE cycle after done (back-to-back spacing N+2 cycles).
- Z/Y may change freely after capture without affecting the result.
- Q, R, ovf and dz are stable from the done cycle until the next accepted start.
  - They may show intermediate values while busy; consumers sample only on done.
- Arithmetic rules:
  - Unsigned operands only.
  - Comparison/subtraction is N+1 bits wide, so the shifted-out MSB of P is never lost.
  - In a non-ovf result, R < Y always holds.

Test Plan:
1. Z=32'd1000, Y=16'd7, start for 1 cycle -> done exactly 17 cycles after the start edge; Q=142, R=6, ovf=0, dz=0; busy high 17 cycles.
2. Z=32'hFFFE0001 (=FFFF*FFFF), Y=16'hFFFF -> Q=16'hFFFF, R=0, ovf=0; the product Q*Y from karatsuba_16 plus R equals Z.
3. Z=32'h12345678, Y=0 -> done 1 cycle after start; dz=1, ovf=1, Q=16'hFFFF, R=16'h5678.
4. Z=32'h00050000, Y=16'd5 -> ovf=1, dz=0, Q=16'hFFFF, R=16'h0000, done 1 cycle after start.
5. Start Z=32'd1000/Y=7, pulse start again at cycle 3 with Z=32'd50/Y=3 -> second start ignored, result Q=142, R=6. Then start Z=32'd50/Y=3 with rst=1 at cycle 5 of RUN -> busy=0, no done pulse, Q=R=0 next cycle. Then a fresh start Z=32'd50/Y=3 -> Q=16, R=2.
6. 500 random back-to-back ops with Z[31:16] < Y, each new start in the first IDLE cycle after done -> every result satisfies Q*Y+R==Z (product via karatsuba_16), R<Y, ovf=0, spacing N+2 cycles.
